// File: rtl/dtw_pkg.sv
// rtl/dtw_pkg.sv - shared encodings and helpers for the multi-bank DTW control core
package dtw_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REF_LOAD = 3'd1,
        ST_Q_HDR    = 3'd2,
        ST_Q_RUN    = 3'd3,
        ST_Q_OUT    = 3'd4
    } state_t;

    // Result flag bit positions inside the 2-bit flag field
    localparam int FLAG_HIT = 0;
    localparam int FLAG_ERR = 1;

    // Query header word1 field offsets
    localparam int HDR_BANK_LSB = 24;
    localparam int HDR_QLEN_LSB = 0;

    // Bank index width: at least one bit even for a single bank
    function automatic int bw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dtw_ref_banks.sv
// rtl/dtw_ref_banks.sv - reference sample banks, one write port and one registered read port
module dtw_ref_banks
    import dtw_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int NUM_BANKS = 4,
    parameter int DEPTH     = 32768,
    localparam int AW = $clog2(DEPTH),
    localparam int BW = bw_of(NUM_BANKS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [BW-1:0]    wbank,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [BW-1:0]    rbank,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [NUM_BANKS][DEPTH];

    // Write port: memory contents survive reset so banks stay usable
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wbank][waddr] <= wdata;
        end
    end

    // Registered read port; output register clears on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[rbank][raddr];
        end
    end

endmodule

// File: rtl/dtw_core_mb.sv
// rtl/dtw_core_mb.sv - multi-bank subsequence-DTW control core (load, query, result framing)
module dtw_core_mb
    import dtw_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int AXIS_WIDTH  = 32,
    parameter int MAX_QLEN    = 250,
    parameter int NUM_BANKS   = 4,
    parameter int MAX_REF_LEN = 32768,
    parameter int REF_INIT    = 0,
    localparam int AW = $clog2(MAX_REF_LEN),
    localparam int BW = bw_of(NUM_BANKS),
    localparam int LW = AW + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  op_mode,
    input  logic [BW-1:0]         bank_sel,
    input  logic [31:0]           ref_len,
    input  logic [WIDTH-1:0]      threshold,
    input  logic                  abort,
    output logic                  busy,
    output logic [NUM_BANKS-1:0]  load_done,
    output logic                  err,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [AXIS_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [AXIS_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  dp_rst,
    output logic                  dp_en,
    output logic [WIDTH-1:0]      dp_sqg,
    output logic [WIDTH-1:0]      dp_rword,
    output logic [31:0]           dp_ref_len,
    output logic [15:0]           dp_qlen,
    input  logic [WIDTH-1:0]      dp_minval,
    input  logic [31:0]           dp_position,
    input  logic                  dp_done,
    output logic [2:0]            dbg_state,
    output logic [31:0]           dbg_nquery
);

    state_t          state;
    logic            hdr_word;
    logic [31:0]     ld_cnt, ld_len;
    logic [BW-1:0]   ld_bank, q_bank;
    logic [7:0]      q_bank_raw;
    logic [31:0]     qid;
    logic [15:0]     qlen;
    logic [31:0]     k;
    logic [AW-1:0]   raddr;
    logic [LW-1:0]   bank_len [NUM_BANKS];
    logic [WIDTH-1:0] res_min;
    logic [31:0]     res_pos;
    logic [1:0]      res_flags;
    logic [1:0]      beat;
    logic [31:0]     word;
    logic            unused_s;

    wire [7:0]  hdr_bank = s_data[HDR_BANK_LSB +: 8];
    wire [15:0] hdr_qlen = s_data[HDR_QLEN_LSB +: 16];
    wire        s_xfer   = s_valid & s_ready;
    wire        m_xfer   = m_valid & m_ready;
    wire        q_active = (k < 32'(qlen));
    wire        step     = (state == ST_Q_RUN) && (q_active ? s_valid : 1'b1);
    wire        ram_we   = (state == ST_REF_LOAD) && s_xfer && !abort;
    wire        hdr_ok   = (32'(hdr_bank) < 32'(NUM_BANKS)) && load_done[hdr_bank[BW-1:0]]
                           && (hdr_qlen != 16'd0) && (32'(hdr_qlen) <= 32'(MAX_QLEN));

    assign unused_s   = ^s_data;
    assign busy       = (state != ST_IDLE);
    assign m_valid    = (state == ST_Q_OUT);
    assign m_last     = (state == ST_Q_OUT) && (beat == 2'd2);
    assign dp_rst     = (state != ST_Q_RUN);
    assign dbg_state  = state;

    // Input stream acceptance depends only on the current state and query progress
    always_comb begin
        s_ready = 1'b0;
        case (state)
            ST_REF_LOAD, ST_Q_HDR: s_ready = 1'b1;
            ST_Q_RUN:              s_ready = q_active;
            default:               s_ready = 1'b0;
        endcase
    end

    // Result beat select: qid, position, then {flags, bank, minval}
    always_comb begin
        word = 32'd0;
        case (beat)
            2'd0:    word = qid;
            2'd1:    word = res_pos;
            default: word = {6'd0, res_flags, q_bank_raw, 16'(res_min)};
        endcase
        m_data = AXIS_WIDTH'(word);
    end

    dtw_ref_banks #(
        .WIDTH     (WIDTH),
        .NUM_BANKS (NUM_BANKS),
        .DEPTH     (MAX_REF_LEN)
    ) u_banks (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .wbank (ld_bank),
        .waddr (ld_cnt[AW-1:0]),
        .wdata (s_data[WIDTH-1:0]),
        .re    (step),
        .rbank (q_bank),
        .raddr (raddr),
        .rdata (dp_rword)
    );

    // Bank lengths are captured on load completion and deliberately not reset
    always_ff @(posedge clk) begin
        if (!rst && !abort && ram_we && (ld_cnt + 32'd1 == ld_len)) begin
            bank_len[ld_bank] <= LW'(ld_len);
        end
    end

    // Main control FSM: command decode, load/query sequencing and result framing
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            err        <= 1'b0;
            load_done  <= {NUM_BANKS{REF_INIT != 0}};
            dbg_nquery <= 32'd0;
            dp_en      <= 1'b0;
            dp_sqg     <= '0;
            dp_ref_len <= 32'd0;
            dp_qlen    <= 16'd0;
            hdr_word   <= 1'b0;
            ld_cnt     <= 32'd0;
            ld_len     <= 32'd0;
            ld_bank    <= '0;
            q_bank     <= '0;
            q_bank_raw <= 8'd0;
            qid        <= 32'd0;
            qlen       <= 16'd0;
            k          <= 32'd0;
            raddr      <= '0;
            res_min    <= '0;
            res_pos    <= 32'd0;
            res_flags  <= 2'd0;
            beat       <= 2'd0;
        end else begin
            err   <= 1'b0;
            dp_en <= 1'b0;
            if (abort) begin
                state <= ST_IDLE;
                beat  <= 2'd0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start && op_mode) begin
                            if (ref_len == 32'd0 || ref_len > 32'(MAX_REF_LEN)
                                || 32'(bank_sel) >= 32'(NUM_BANKS)) begin
                                err <= 1'b1;
                            end else begin
                                load_done[bank_sel] <= 1'b0;
                                ld_bank <= bank_sel;
                                ld_len  <= ref_len;
                                ld_cnt  <= 32'd0;
                                state   <= ST_REF_LOAD;
                            end
                        end else if (start) begin
                            hdr_word <= 1'b0;
                            state    <= ST_Q_HDR;
                        end
                    end
                    ST_REF_LOAD: begin
                        if (s_xfer) begin
                            ld_cnt <= ld_cnt + 32'd1;
                            if (ld_cnt + 32'd1 == ld_len) begin
                                load_done[ld_bank] <= 1'b1;
                                state <= ST_IDLE;
                            end
                        end
                    end
                    ST_Q_HDR: begin
                        if (s_xfer && !hdr_word) begin
                            qid      <= s_data[31:0];
                            hdr_word <= 1'b1;
                        end else if (s_xfer) begin
                            q_bank_raw <= hdr_bank;
                            q_bank     <= hdr_bank[BW-1:0];
                            qlen       <= hdr_qlen;
                            k          <= 32'd0;
                            raddr      <= '0;
                            beat       <= 2'd0;
                            if (hdr_ok) begin
                                dp_qlen    <= hdr_qlen;
                                dp_ref_len <= 32'(bank_len[hdr_bank[BW-1:0]]);
                                state      <= ST_Q_RUN;
                            end else begin
                                err       <= 1'b1;
                                res_flags <= '0;
                                res_flags[FLAG_ERR] <= 1'b1;
                                res_min   <= '1;
                                res_pos   <= 32'd0;
                                state     <= ST_Q_OUT;
                            end
                        end
                    end
                    ST_Q_RUN: begin
                        if (step) begin
                            k      <= k + 32'd1;
                            raddr  <= (32'(raddr) + 32'd1 == dp_ref_len) ? '0 : raddr + AW'(1);
                            dp_en  <= 1'b1;
                            dp_sqg <= q_active ? s_data[WIDTH-1:0] : '0;
                        end
                        if (dp_done) begin
                            res_min   <= dp_minval;
                            res_pos   <= dp_position;
                            res_flags <= '0;
                            res_flags[FLAG_HIT] <= (dp_minval <= threshold);
                            state     <= ST_Q_OUT;
                        end
                    end
                    ST_Q_OUT: begin
                        if (m_xfer && beat == 2'd2) begin
                            dbg_nquery <= dbg_nquery + 32'd1;
                            beat       <= 2'd0;
                            state      <= ST_IDLE;
                        end else if (m_xfer) begin
                            beat <= beat + 2'd1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
